// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and the transmit sequencer state type.
// Kept separate so the receive side can reuse the same constants.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StLoad,
        StStart,
        StData,
        StStop
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: bit_end marks the last cycle of each serial bit.
// Restarts on clr or after every bit end, so back-to-back bits need no external reload.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT * 2);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops bytes from the TX FIFO and sends them as 8N1/8N2 frames,
// LSB first. A pop is held off while the FIFO is accepting a push, since push wins there.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic                 fifo_empty,
    input  logic                 fifo_push,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_pop,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 bit_end;
    logic                 timer_clr;
    logic                 last_stop;

    // Every state change restarts the bit period.
    assign timer_clr = (state_d != state_q);
    assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        fifo_pop   = 1'b0;
        tx_done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_en && !fifo_empty) begin
                    state_d = StPop;
                end
            end
            StPop: begin
                fifo_pop = !fifo_push;
                if (!fifo_push) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                shreg_d    = fifo_data;
                bit_idx_d  = '0;
                stop_idx_d = 1'b0;
                state_d    = StStart;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (last_stop) begin
                        tx_done = 1'b1;
                        state_d = StIdle;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level decoded from registered state only, so tx cannot glitch.
    always_comb begin
        unique case (state_q)
            StStart: tx = START_BIT;
            StData:  tx = shreg_q[0];
            default: tx = STOP_BIT;
        endcase
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
        end
    end

endmodule
